// File: rtl/host_cmd_parser_pkg.sv
// Shared types and constants for the host command parser: FSM state codes,
// the packet header record and the fixed header/checksum framing sizes.
package host_cmd_parser_pkg;

    typedef logic [3:0] parser_state_t;

    localparam parser_state_t ST_IDLE    = 4'd0;
    localparam parser_state_t ST_CMD     = 4'd1;
    localparam parser_state_t ST_LEN_HI  = 4'd2;
    localparam parser_state_t ST_LEN_LO  = 4'd3;
    localparam parser_state_t ST_PAYLOAD = 4'd4;
    localparam parser_state_t ST_CK_HI   = 4'd5;
    localparam parser_state_t ST_CK_LO   = 4'd6;
    localparam parser_state_t ST_FORWARD = 4'd7;
    localparam parser_state_t ST_DISCARD = 4'd8;

    typedef struct packed {
        logic [7:0]  destination;
        logic [7:0]  command;
        logic [23:0] length;
    } cmd_header_t;

    localparam int HDR_WORDS = 4;
    localparam int CK_WORDS  = 2;

    // States in which the parser is waiting on the host for the next word.
    function automatic logic is_rx_state(input parser_state_t s);
        return s inside {ST_CMD, ST_LEN_HI, ST_LEN_LO, ST_PAYLOAD,
                         ST_CK_HI, ST_CK_LO, ST_DISCARD};
    endfunction

endpackage

// File: rtl/host_cmd_buffer.sv
// Payload buffer: simple dual-port RAM with one write port and one
// registered read port whose output holds while rd_en is low.
module host_cmd_buffer #(
    parameter int width  = 16,
    parameter int addr_w = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [addr_w-1:0] wr_addr,
    input  logic [width-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [addr_w-1:0] rd_addr,
    output logic [width-1:0]  rd_data
);

    logic [width-1:0] mem [2**addr_w];

    // NOTE: the array has no reset so it maps onto block RAM; every word is
    // written before it is read, so its power-up contents never matter.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/host_cmd_parser.sv
// Host command deframer: buffers payload, verifies the 32-bit checksum and
// forwards good packets. HOST_CMD_PARSER_TIMEOUT_EN adds an inter-word timeout.
module host_cmd_parser
    import host_cmd_parser_pkg::*;
#(
    parameter int host_width  = 16,
    parameter int max_log_len = 10
`ifdef HOST_CMD_PARSER_TIMEOUT_EN
    ,
    parameter int timeout_cycles = 65535
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [host_width-1:0] in_data,
    input  logic                  in_enable,
    output logic                  in_ready,
    output logic [7:0]            out_destination,
    output logic [7:0]            out_command,
    output logic [23:0]           out_length,
    output logic [host_width-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  err_checksum,
    output logic                  err_overflow,
`ifdef HOST_CMD_PARSER_TIMEOUT_EN
    output logic                  err_timeout,
`endif
    output logic [15:0]           pkt_count
);

    localparam logic [23:0] MAX_LEN = 24'(2 ** max_log_len);

    parser_state_t          state;
    cmd_header_t            hdr;
    cmd_header_t            out_hdr;
    logic [max_log_len-1:0] idx;
    logic [31:0]            sum;
    logic [15:0]            ck_hi;
    logic [24:0]            disc_cnt;
    logic [max_log_len:0]   issue_idx;
    logic                   data_gate;
    logic [host_width-1:0]  rd_data;

    logic                   accept;
    logic [23:0]            new_len;
    logic [max_log_len:0]   total_beats;
    logic [max_log_len:0]   last_beat;
    logic                   issue;
    logic                   rd_en;

    assign in_ready    = (state != ST_FORWARD);
    assign accept      = in_ready && in_enable;
    assign new_len     = {hdr.length[23:16], in_data[15:0]};
    // A zero-length packet still produces one (all-zero) beat.
    assign total_beats = (hdr.length == 24'd0) ? {{max_log_len{1'b0}}, 1'b1}
                                               : hdr.length[max_log_len:0];
    assign last_beat   = total_beats - {{max_log_len{1'b0}}, 1'b1};
    assign issue       = (state == ST_FORWARD) && (issue_idx != total_beats)
                         && (!out_valid || out_ready);
    assign rd_en       = issue && (hdr.length != 24'd0);

    assign out_destination = out_hdr.destination;
    assign out_command     = out_hdr.command;
    assign out_length      = out_hdr.length;
    assign out_data        = data_gate ? rd_data : '0;

`ifdef HOST_CMD_PARSER_TIMEOUT_EN
    localparam int GAP_W = $clog2(timeout_cycles + 1);
    logic [GAP_W-1:0] gap_cnt;
`endif

    host_cmd_buffer #(
        .width  (host_width),
        .addr_w (max_log_len)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (accept && (state == ST_PAYLOAD)),
        .wr_addr (idx),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr (issue_idx[max_log_len-1:0]),
        .rd_data (rd_data)
    );

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            hdr          <= '0;
            out_hdr      <= '0;
            idx          <= '0;
            sum          <= '0;
            ck_hi        <= '0;
            disc_cnt     <= '0;
            issue_idx    <= '0;
            data_gate    <= 1'b0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            err_checksum <= 1'b0;
            err_overflow <= 1'b0;
            pkt_count    <= '0;
`ifdef HOST_CMD_PARSER_TIMEOUT_EN
            err_timeout  <= 1'b0;
            gap_cnt      <= '0;
`endif
        end else begin
            err_checksum <= 1'b0;
            err_overflow <= 1'b0;
            case (state)
                ST_IDLE: if (accept) begin
                    hdr.destination <= in_data[7:0];
                    sum   <= '0;
                    idx   <= '0;
                    state <= ST_CMD;
                end
                ST_CMD: if (accept) begin
                    hdr.command <= in_data[7:0];
                    state       <= ST_LEN_HI;
                end
                ST_LEN_HI: if (accept) begin
                    hdr.length[23:16] <= in_data[7:0];
                    state             <= ST_LEN_LO;
                end
                ST_LEN_LO: if (accept) begin
                    hdr.length[15:0] <= in_data[15:0];
                    if (new_len == 24'd0) begin
                        state <= ST_CK_HI;
                    end else if (new_len > MAX_LEN) begin
                        disc_cnt <= {1'b0, new_len} + 25'(CK_WORDS - 1);
                        state    <= ST_DISCARD;
                    end else begin
                        state <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: if (accept) begin
                    sum <= sum + 32'(in_data);
                    idx <= idx + 1'b1;
                    if (24'(idx) == hdr.length - 24'd1) state <= ST_CK_HI;
                end
                ST_CK_HI: if (accept) begin
                    ck_hi <= in_data[15:0];
                    state <= ST_CK_LO;
                end
                ST_CK_LO: if (accept) begin
                    if ({ck_hi, in_data[15:0]} == sum) begin
                        out_hdr   <= hdr;
                        issue_idx <= '0;
                        state     <= ST_FORWARD;
                    end else begin
                        err_checksum <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                ST_FORWARD: begin
                    // The read register only reloads on issue, so a stalled
                    // beat holds its data and last flag.
                    if (issue) begin
                        issue_idx <= issue_idx + 1'b1;
                        out_valid <= 1'b1;
                        out_last  <= (issue_idx == last_beat);
                        data_gate <= (hdr.length != 24'd0);
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            pkt_count <= pkt_count + 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                end
                ST_DISCARD: if (accept) begin
                    if (disc_cnt == 25'd0) begin
                        err_overflow <= 1'b1;
                        state        <= ST_IDLE;
                    end else begin
                        disc_cnt <= disc_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
`ifdef HOST_CMD_PARSER_TIMEOUT_EN
            err_timeout <= 1'b0;
            if (accept || !is_rx_state(state)) begin
                gap_cnt <= '0;
            end else if (gap_cnt == GAP_W'(timeout_cycles - 1)) begin
                gap_cnt     <= '0;
                err_timeout <= 1'b1;
                state       <= ST_IDLE;
            end else begin
                gap_cnt <= gap_cnt + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_host_cmd_parser.sv
// Directed bench for host_cmd_parser; define HOST_CMD_PARSER_TIMEOUT_EN to
// also exercise the inter-word timeout.
module tb_host_cmd_parser;
    import host_cmd_parser_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_enable;
    logic        in_ready;
    logic [7:0]  out_destination;
    logic [7:0]  out_command;
    logic [23:0] out_length;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        err_checksum;
    logic        err_overflow;
    logic [15:0] pkt_count;
`ifdef HOST_CMD_PARSER_TIMEOUT_EN
    logic        err_timeout;
`endif

    always #5 clk = ~clk;

    host_cmd_parser #(
        .host_width  (16),
        .max_log_len (10)
`ifdef HOST_CMD_PARSER_TIMEOUT_EN
        ,
        .timeout_cycles (100)
`endif
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_data         (in_data),
        .in_enable       (in_enable),
        .in_ready        (in_ready),
        .out_destination (out_destination),
        .out_command     (out_command),
        .out_length      (out_length),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last),
        .err_checksum    (err_checksum),
        .err_overflow    (err_overflow),
`ifdef HOST_CMD_PARSER_TIMEOUT_EN
        .err_timeout     (err_timeout),
`endif
        .pkt_count       (pkt_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Stimulus and capture state.
    logic [15:0] tx_q[$];
    logic [15:0] pl[$];
    logic [15:0] beat_data[$];
    logic        beat_last[$];
    logic [39:0] beat_hdr[$];
    int ck_cycles = 0, ov_cycles = 0, to_cycles = 0, valid_cycles = 0;
    int stall_viol = 0, stall_events = 0, inr_viol = 0;
    bit ready_mode = 1'b0;

    function automatic logic [31:0] pl_sum();
        logic [31:0] s = '0;
        foreach (pl[i]) s += 32'(pl[i]);
        return s;
    endfunction

    task automatic queue_packet(input logic [7:0] d, input logic [7:0] c,
                                input logic [23:0] len, input logic [31:0] ck);
        tx_q.push_back({8'h00, d});
        tx_q.push_back({8'h00, c});
        tx_q.push_back({8'h00, len[23:16]});
        tx_q.push_back(len[15:0]);
        foreach (pl[i]) tx_q.push_back(pl[i]);
        tx_q.push_back(ck[31:16]);
        tx_q.push_back(ck[15:0]);
    endtask

    // Drives every queued word; returns #1 after the edge that took the last one.
    task automatic send_tx();
        while (tx_q.size() > 0) begin
            int  guard = 0;
            bit  took  = 1'b0;
            in_data   = tx_q.pop_front();
            in_enable = 1'b1;
            while (!took && guard < 2000) begin
                took = in_ready;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!took) begin
                check("send_timeout", 0, 1);
                tx_q.delete();
            end
        end
        in_enable = 1'b0;
        in_data   = '0;
    endtask

    task automatic wait_beats(input int n, input int budget, input string tag);
        int c = 0;
        while (beat_data.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        repeat (2) @(negedge clk);
        check(tag, 64'(beat_data.size()), 64'(n));
    endtask

    task automatic clear_capture();
        beat_data.delete();
        beat_last.delete();
        beat_hdr.delete();
    endtask

    // Output monitor, sampled on the falling edge.
    initial begin
        bit          prev_stall = 1'b0;
        logic [15:0] prev_data  = '0;
        logic        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
                stall_viol++;
            if (out_valid && out_ready) begin
                beat_data.push_back(out_data);
                beat_last.push_back(out_last);
                beat_hdr.push_back({out_destination, out_command, out_length});
            end
            if (out_valid) valid_cycles++;
            if (out_valid && in_ready) inr_viol++;
            if (out_valid && !out_ready) stall_events++;
            if (err_checksum) ck_cycles++;
            if (err_overflow) ov_cycles++;
`ifdef HOST_CMD_PARSER_TIMEOUT_EN
            if (err_timeout) to_cycles++;
`endif
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    // Consumer ready: always high, or the 1,0,0,1 stall pattern.
    initial begin
        int phase = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) out_ready = (phase % 4 == 0) || (phase % 4 == 3);
            else            out_ready = 1'b1;
            phase++;
        end
    end

    task automatic send_good_small(input logic [7:0] d, input string tag);
        pl = '{16'h0061, 16'h00A9, 16'h00A3};
        clear_capture();
        queue_packet(d, 8'h20, 24'd3, 32'h0000_01AD);
        send_tx();
        wait_beats(3, 50, {tag, "_beats"});
        if (beat_data.size() == 3) begin
            check({tag, "_hdr"}, 64'(beat_hdr[0]), {24'h0, d, 8'h20, 24'd3});
            check({tag, "_data"}, {16'h0, beat_data[0], beat_data[1], beat_data[2]},
                  64'h0000_0061_00A9_00A3);
            check({tag, "_last"}, {61'h0, beat_last[0], beat_last[1], beat_last[2]}, 64'b001);
        end
    endtask

    initial begin
        int base_pkt;
        int base_valid;
        reset     = 1'b1;
        in_enable = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 1);
        check("rst_out_flags", {60'h0, out_valid, out_last, err_checksum, err_overflow}, 0);
        check("rst_pkt_count", 64'(pkt_count), 0);
        check("rst_hdr_data", {out_destination, out_command, out_length, out_data}, 0);

        // Good 3-word packet, with first-beat latency.
        pl = '{16'h0061, 16'h00A9, 16'h00A3};
        clear_capture();
        queue_packet(8'h01, 8'h20, 24'd3, 32'h0000_01AD);
        send_tx();
        @(negedge clk);
        check("lat_cycle1_valid", 64'(out_valid), 0);
        @(negedge clk);
        check("lat_cycle2_valid", 64'(out_valid), 1);
        wait_beats(3, 50, "t1_beats");
        if (beat_data.size() == 3) begin
            check("t1_hdr", 64'(beat_hdr[0]), {24'h0, 8'h01, 8'h20, 24'd3});
            check("t1_data", {16'h0, beat_data[0], beat_data[1], beat_data[2]},
                  64'h0000_0061_00A9_00A3);
            check("t1_last", {61'h0, beat_last[0], beat_last[1], beat_last[2]}, 64'b001);
        end
        check("t1_pkt_count", 64'(pkt_count), 1);
        check("t1_in_ready_idle", 64'(in_ready), 1);
        check("t1_out_valid_off", 64'(out_valid), 0);

        // Bad checksum immediately followed by a good packet.
        base_valid = valid_cycles;
        clear_capture();
        queue_packet(8'h01, 8'h20, 24'd3, 32'h0000_01AE);
        pl = '{16'h0011, 16'h0022, 16'hFFF0};
        queue_packet(8'h05, 8'h21, 24'd3, 32'h0001_0023);
        send_tx();
        wait_beats(3, 60, "t2_beats");
        check("t2_ck_pulse", 64'(ck_cycles), 1);
        if (beat_data.size() == 3) begin
            check("t2_hdr", 64'(beat_hdr[0]), {24'h0, 8'h05, 8'h21, 24'd3});
            check("t2_data", {16'h0, beat_data[0], beat_data[1], beat_data[2]},
                  64'h0000_0011_0022_FFF0);
        end
        check("t2_valid_cycles", 64'(valid_cycles - base_valid), 3);
        check("t2_pkt_count", 64'(pkt_count), 2);

        // Overflow: length 1025 -> 1027 words discarded.
        pl.delete();
        for (int i = 0; i < 1025; i++) pl.push_back(16'(i * 7));
        queue_packet(8'h02, 8'h30, 24'h000401, 32'h0);
        check("t3_words_queued", 64'(tx_q.size()), 64'(HDR_WORDS + 1027));
        void'(tx_q.pop_back());
        send_tx();
        @(negedge clk);
        check("t3_no_early_ovf", 64'(ov_cycles), 0);
        tx_q.push_back(16'h0000);
        send_tx();
        @(negedge clk);
        check("t3_ovf_pulse", 64'(err_overflow), 1);
        @(negedge clk);
        check("t3_ovf_once", 64'(ov_cycles), 1);
        send_good_small(8'h06, "t3_after");
        check("t3_pkt_count", 64'(pkt_count), 3);
        check("t3_valid_in_ovf", 64'(valid_cycles - base_valid), 6);

        // Maximum length 1024 is accepted.
        pl.delete();
        for (int i = 0; i < 1024; i++) pl.push_back(16'(i));
        clear_capture();
        queue_packet(8'h07, 8'h31, 24'd1024, 32'h0007_FE00);
        send_tx();
        wait_beats(1024, 1500, "t_max_beats");
        begin
            int bad = 0;
            foreach (beat_data[i])
                if (beat_data[i] !== 16'(i) || beat_last[i] !== (i == 1023)) bad++;
            check("t_max_content", 64'(bad), 0);
        end
        check("t_max_ovf_none", 64'(ov_cycles), 1);

        // 10-word audio packet with consumer stalls.
        pl = '{16'h0100, 16'h0302, 16'h0504, 16'h0706, 16'h0908,
               16'h0B0A, 16'h0D0C, 16'h0F0E, 16'h1110, 16'h1312};
        clear_capture();
        stall_viol   = 0;
        stall_events = 0;
        inr_viol     = 0;
        queue_packet(8'h03, 8'h41, 24'd10, 32'h0000_645A);
        ready_mode = 1'b1;
        send_tx();
        wait_beats(10, 100, "t4_beats");
        ready_mode = 1'b0;
        if (beat_data.size() == 10) begin
            int bad = 0;
            foreach (beat_data[i])
                if (beat_data[i] !== pl[i] || beat_last[i] !== (i == 9)) bad++;
            check("t4_order", 64'(bad), 0);
        end
        check("t4_stalls_seen", 64'(stall_events > 0), 1);
        check("t4_stall_hold", 64'(stall_viol), 0);
        check("t4_in_ready_low", 64'(inr_viol), 0);

        // Zero-length packet.
        pl.delete();
        clear_capture();
        base_pkt = int'(pkt_count);
        queue_packet(8'h04, 8'h50, 24'd0, 32'h0);
        send_tx();
        wait_beats(1, 20, "t5_beats");
        if (beat_data.size() == 1) begin
            check("t5_data", 64'(beat_data[0]), 0);
            check("t5_last", 64'(beat_last[0]), 1);
            check("t5_hdr", 64'(beat_hdr[0]), {24'h0, 8'h04, 8'h50, 24'd0});
        end
        check("t5_pkt_count", 64'(int'(pkt_count) - base_pkt), 1);

        // Reset during the second payload word.
        pl = '{16'h1234};
        queue_packet(8'h09, 8'h60, 24'd3, 32'h0);
        repeat (2) void'(tx_q.pop_back());
        send_tx();
        in_data   = 16'h5678;
        in_enable = 1'b1;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        in_enable = 1'b0;
        @(negedge clk);
        check("t6_rst_pkt_count", 64'(pkt_count), 0);
        check("t6_rst_hdr", {out_destination, out_command, out_length, out_data}, 0);
        check("t6_rst_flags", {59'h0, in_ready, out_valid, out_last, err_checksum, err_overflow},
              64'b10000);
        send_good_small(8'h01, "t6_after");
        check("t6_pkt_count", 64'(pkt_count), 1);
        check("t6_no_err", 64'(ck_cycles), 1);

`ifdef HOST_CMD_PARSER_TIMEOUT_EN
        // Stall for the timeout inside PAYLOAD.
        pl = '{16'h0AAA};
        queue_packet(8'h0A, 8'h70, 24'd3, 32'h0);
        repeat (2) void'(tx_q.pop_back());
        send_tx();
        repeat (95) @(negedge clk);
        check("to_not_early", 64'(to_cycles), 0);
        repeat (20) @(negedge clk);
        check("to_pulse_once", 64'(to_cycles), 1);
        send_good_small(8'h0B, "to_after");
        check("to_pkt_count", 64'(pkt_count), 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/host_cmd_parser.md
Name: host_cmd_parser

Overview:
- Sits directly downstream of the host input FIFO (FX2 / host_in side) and upstream of the slot and command dispatch logic.
- Deframes host command packets: destination, command, 24-bit length, N payload words, 32-bit checksum.
- Buffers the payload, checks the checksum, and forwards only verified packets as a header plus a ready/valid word stream.
- Counts and flags malformed packets.

Parameters:
- host_width, 16: host word width; payload word width.
- max_log_len, 10: log2 of payload buffer depth (1024 words); maximum accepted length.
- timeout_cycles, 65535: inter-word gap limit (optional feature only).

Ports:
- clk  in  1  host clock domain clock
- reset  in  1  synchronous, active-high reset
- in_data  in  host_width  incoming host word
- in_enable  in  1  in_data valid
- in_ready  out  1  parser can accept a word; transfer occurs when in_ready && in_enable
- out_destination  out  8  slot/destination of the forwarded packet
- out_command  out  8  command byte
- out_length  out  24  payload word count
- out_data  out  host_width  payload word
- out_valid  out  1  out_data/header valid
- out_ready  in  1  consumer accepts; beat transfers when out_valid && out_ready
- out_last  out  1  final beat of packet
- err_checksum  out  1  one-cycle pulse on checksum mismatch
- err_overflow  out  1  one-cycle pulse when length exceeds 2**max_log_len
- pkt_count  out  16  verified packets forwarded, wraps

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, out_last=0, err_*=0, pkt_count=0; out_destination/command/length/data=0.
- Packet word order:
  - w0: destination = bits[7:0]; upper bits ignored.
  - w1: command = bits[7:0].
  - w2: length[23:16] = bits[7:0].
  - w3: length[15:0].
  - N payload words.
  - Checksum high word, then checksum low word.
- Checksum = 32-bit modulo sum of payload words, zero-extended; header words are excluded.
- States: IDLE -> CMD -> LEN_HI -> LEN_LO -> PAYLOAD -> CK_HI -> CK_LO -> FORWARD -> IDLE. Each receive state advances only on an accepted word.
- LEN_LO exits:
  - length==0 -> CK_HI.
  - length>2**max_log_len -> DISCARD: consume length+2 words, pulse err_overflow on the last one, -> IDLE.
- PAYLOAD: write buffer[idx], accumulate sum, idx++. Leave when idx==length-1 is accepted.
- CK_LO on accept:
  - Mismatch: pulse err_checksum the next cycle, -> IDLE, nothing forwarded.
  - Match: -> FORWARD.
- in_ready=0 only in FORWARD; 1 in all other states.
- FORWARD:
  - Header outputs are held stable for the entire packet.
  - Buffer is synchronous read; first out_valid 2 cycles after the CK_LO accept.
  - out_data/out_last must hold while out_valid && !out_ready.
  - One beat per cycle when out_ready stays high (prefetch next address).
  - out_last=1 on beat length-1.
  - length==0: a single beat, out_data=0, out_last=1.
  - After the last beat transfers: pkt_count++, out_valid=0 the next cycle, -> IDLE.
- Reset asserted mid-packet: abort immediately to reset values; partial packet discarded; no err pulse.
- Simultaneous err pulse and a new word in IDLE: the word is accepted as the next packet's destination.

Optional Feature:
- Macro: HOST_CMD_PARSER_TIMEOUT_EN.
- Defined: a gap counter resets on each accepted word and counts idle cycles in CMD..CK_LO and DISCARD. On reaching timeout_cycles: abort to IDLE, pulse err_timeout (extra 1-bit output port, present only with the macro).
- Undefined: no counter and no port; the parser waits indefinitely.

Decomposition:
- Shared package:
  - Parser state enum.
  - Header struct (destination, command, length).
  - HDR_WORDS=4, CK_WORDS=2.
- Sub-module: host_cmd_buffer, a simple dual-port synchronous RAM of depth 2**max_log_len and width host_width, one write port and one registered read port.

Test Plan:
- Dest 0x01, cmd 0x20, len 3, data 0x0061/0x00A9/0x00A3, checksum 0x0000,0x01AD -> header 01/20/3, three beats, last on third, pkt_count=1.
- Same packet with checksum low word 0x01AE -> err_checksum pulse, no out_valid, pkt_count unchanged; next good packet forwarded.
- Length 0x000401 (1025) -> 1027 words consumed, err_overflow once, parser accepts a following valid packet.
- 10-word audio packet (0x0100,0x0302,...) with out_ready toggled 1,0,0,1 -> data stable while stalled, all 10 beats in order, in_ready=0 throughout FORWARD.
- Length 0, checksum 0,0 -> single beat, out_data=0, out_last=1.
- Reset asserted during PAYLOAD word 2 -> outputs at reset values next cycle; a subsequent full packet parses correctly; with HOST_CMD_PARSER_TIMEOUT_EN and timeout_cycles=100, a 100-cycle stall in PAYLOAD -> err_timeout pulse, return to IDLE.
